// File: rtl/mpu_scheduler_pkg.sv
// Shared constants, state encoding and the MPU6050 init table for the scheduler.
package mpu_scheduler_pkg;

    localparam logic [7:0] MPU_DEV_ADDR     = 8'hD0;
    localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;
    localparam int         INIT_LEN         = 5;
    localparam int         IDX_W            = $clog2(INIT_LEN);
    localparam int         PACK_W           = 112;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INIT_ISS  = 3'd1;
    localparam logic [2:0] ST_INIT_WAIT = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_RD_ISS    = 3'd4;
    localparam logic [2:0] ST_RD_WAIT   = 3'd5;
    localparam logic [2:0] ST_RECOVER   = 3'd6;
    localparam logic [2:0] ST_FAULT     = 3'd7;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } init_entry_t;

    // Power-up register writes: wake, sample divider, DLPF, gyro range, accel range.
    function automatic init_entry_t init_entry(input logic [IDX_W-1:0] idx);
        init_entry_t e;
        case (idx)
            3'd1:    e = '{addr: 8'h19, data: 8'h07};
            3'd2:    e = '{addr: 8'h1A, data: 8'h03};
            3'd3:    e = '{addr: 8'h1B, data: 8'h08};
            3'd4:    e = '{addr: 8'h1C, data: 8'h08};
            default: e = '{addr: 8'h6B, data: 8'h00};
        endcase
        return e;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mpu_scheduler_if.sv
// Handshake and register bus between the scheduler and the mpu I2C engine.
interface mpu_scheduler_if;
    import mpu_scheduler_pkg::*;

    logic              mpu_init_start;
    logic              mpu_read_start;
    logic              mpu_read_done;
    logic [PACK_W-1:0] mpu_data_pack;
    logic              mpu_error;
    logic              mpu_error_reset;
    logic [7:0]        mpu_device_addr;
    logic [7:0]        mpu_register_addr;
    logic [7:0]        mpu_register_data;
    logic [7:0]        mpu_read_start_addr;

    modport master (
        output mpu_init_start, mpu_read_start, mpu_error_reset,
        output mpu_device_addr, mpu_register_addr, mpu_register_data, mpu_read_start_addr,
        input  mpu_read_done, mpu_data_pack, mpu_error
    );

    modport slave (
        input  mpu_init_start, mpu_read_start, mpu_error_reset,
        input  mpu_device_addr, mpu_register_addr, mpu_register_data, mpu_read_start_addr,
        output mpu_read_done, mpu_data_pack, mpu_error
    );
endinterface

// File: rtl/mpu_scheduler_tick_gen.sv
// Sample-rate divider: one-cycle tick every TICK_DIV cycles while enabled.
module mpu_scheduler_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int           W    = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    // Free-running phase counter, parked at zero while disabled so each enable starts a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              cnt <= '0;
        else if (!en)         cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = en && (cnt == LAST);
endmodule

// File: rtl/mpu_scheduler.sv
// Sequencer for the mpu I2C engine: init table writes, periodic 14-byte burst reads, bounded retry.
//
//  state      | meaning
//  IDLE       | waiting for enable
//  INIT_ISS   | drive table[idx], pulse init_start
//  INIT_WAIT  | fixed settle time for the write in flight
//  RUN        | sampling, waiting for the next tick
//  RD_ISS     | pulse read_start
//  RD_WAIT    | waiting for read_done, error or timeout
//  RECOVER    | error_reset pulsed, idle before retry
//  FAULT      | retries exhausted, bus quiet until enable drops
module mpu_scheduler
    import mpu_scheduler_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SAMPLE_HZ   = 1000,
    parameter int WR_WAIT_CYC = 25000,
    parameter int RD_TIMEOUT  = 50000,
    parameter int RECOVER_CYC = 1000,
    parameter int MAX_RETRY   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    mpu_scheduler_if.master   bus,
    output logic              sample_valid,
    output logic [PACK_W-1:0] sample_data,
    output logic              ready,
    output logic              fault,
    output logic [7:0]        overrun_cnt
);
    localparam int TICK_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int TMR_W    = $clog2(max3(WR_WAIT_CYC, RD_TIMEOUT, RECOVER_CYC));
    localparam int RETRY_W  = $clog2(MAX_RETRY + 2);

    // Timer loads are one less than the duration: the terminal-count cycle is included.
    localparam logic [TMR_W-1:0]   WR_LOAD   = TMR_W'(WR_WAIT_CYC - 1);
    localparam logic [TMR_W-1:0]   RD_LOAD   = TMR_W'(RD_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   REC_LOAD  = TMR_W'(RECOVER_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(INIT_LEN - 1);

    logic [2:0]         state;
    logic [IDX_W-1:0]   idx;
    logic [RETRY_W-1:0] retry;
    logic [TMR_W-1:0]   tmr;
    logic               tick;
    logic               init_start_r, read_start_r, error_reset_r;
    logic [7:0]         reg_addr_r, reg_data_r;
    init_entry_t        ent;
    init_entry_t        ent_first;

    assign ent       = init_entry(idx);
    assign ent_first = init_entry('0);

    assign bus.mpu_init_start      = init_start_r;
    assign bus.mpu_read_start      = read_start_r;
    assign bus.mpu_error_reset     = error_reset_r;
    assign bus.mpu_register_addr   = reg_addr_r;
    assign bus.mpu_register_data   = reg_data_r;
    assign bus.mpu_device_addr     = MPU_DEV_ADDR;
    assign bus.mpu_read_start_addr = REG_ACCEL_XOUT_H;

    mpu_scheduler_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (ready),
        .tick (tick)
    );

    // Main sequencer; all bus pulses default low and are set for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            idx           <= '0;
            retry         <= '0;
            tmr           <= '0;
            init_start_r  <= 1'b0;
            read_start_r  <= 1'b0;
            error_reset_r <= 1'b0;
            sample_valid  <= 1'b0;
            sample_data   <= '0;
            ready         <= 1'b0;
            fault         <= 1'b0;
            reg_addr_r    <= ent_first.addr;
            reg_data_r    <= ent_first.data;
        end else begin
            init_start_r  <= 1'b0;
            read_start_r  <= 1'b0;
            error_reset_r <= 1'b0;
            sample_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_INIT_ISS;
                        idx   <= '0;
                        retry <= '0;
                    end
                end
                ST_INIT_ISS: begin
                    reg_addr_r   <= ent.addr;
                    reg_data_r   <= ent.data;
                    init_start_r <= 1'b1;
                    tmr          <= WR_LOAD;
                    state        <= ST_INIT_WAIT;
                end
                ST_INIT_WAIT: begin
                    if (bus.mpu_error) begin
                        error_reset_r <= 1'b1;
                        if (!enable) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_RECOVER;
                            tmr   <= REC_LOAD;
                            retry <= retry + 1'b1;
                        end
                    end else if (tmr == '0) begin
                        if (!enable) begin
                            state <= ST_IDLE;
                        end else if (idx == LAST_IDX) begin
                            state <= ST_RUN;
                            ready <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_INIT_ISS;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        ready <= 1'b0;
                    end else if (tick) begin
                        state <= ST_RD_ISS;
                    end
                end
                ST_RD_ISS: begin
                    read_start_r <= 1'b1;
                    tmr          <= RD_LOAD;
                    state        <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    // Error outranks a simultaneous read_done: the pack is discarded.
                    if (bus.mpu_error) begin
                        error_reset_r <= 1'b1;
                        if (!enable) begin
                            state <= ST_IDLE;
                            ready <= 1'b0;
                        end else begin
                            state <= ST_RECOVER;
                            tmr   <= REC_LOAD;
                            retry <= retry + 1'b1;
                        end
                    end else if (bus.mpu_read_done) begin
                        sample_data  <= bus.mpu_data_pack;
                        sample_valid <= 1'b1;
                        retry        <= '0;
                        if (!enable) begin
                            state <= ST_IDLE;
                            ready <= 1'b0;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else if (tmr == '0) begin
                        if (!enable) begin
                            state <= ST_IDLE;
                            ready <= 1'b0;
                        end else begin
                            error_reset_r <= 1'b1;
                            state         <= ST_RECOVER;
                            tmr           <= REC_LOAD;
                            retry         <= retry + 1'b1;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_RECOVER: begin
                    // ready distinguishes a failed read (retry it) from a failed init (replay table).
                    if (tmr == '0) begin
                        if (retry > RETRY_LIM) begin
                            state <= ST_FAULT;
                            fault <= 1'b1;
                            ready <= 1'b0;
                        end else if (!enable) begin
                            state <= ST_IDLE;
                            ready <= 1'b0;
                        end else if (ready) begin
                            state <= ST_RD_ISS;
                        end else begin
                            idx   <= '0;
                            state <= ST_INIT_ISS;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        fault <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ticks that land while a read or recovery is in progress are dropped and counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overrun_cnt <= 8'd0;
        else if (tick && (state != ST_RUN) && (overrun_cnt != 8'hFF))
            overrun_cnt <= overrun_cnt + 8'd1;
    end
endmodule

// File: tb/tb_mpu_scheduler.sv
// Directed bench for mpu_scheduler with a small fake mpu engine.
module tb_mpu_scheduler;

    localparam logic [111:0] PACK_A = 112'h0102030405060708090A0B0C0D0E;
    localparam logic [111:0] PACK_B = 112'h1112131415161718191A1B1C1D1E;
    localparam logic [111:0] PACK_D = 112'h00112233445566778899AABBCCDD;
    localparam logic [111:0] BAD    = 112'hDEADDEADDEADDEADDEADDEADDEAD;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         gap;
    } init_vec_t;

    typedef struct {
        int           delay;
        int           mode;
        logic [111:0] pack;
        logic [111:0] exp_data;
        int           exp_lat;
        int           exp_er;
    } rd_vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         sample_valid;
    logic [111:0] sample_data;
    logic         ready;
    logic         fault;
    logic [7:0]   overrun_cnt;

    mpu_scheduler_if bus ();

    mpu_scheduler #(
        .CLK_HZ(1000), .SAMPLE_HZ(10), .WR_WAIT_CYC(20),
        .RD_TIMEOUT(50), .RECOVER_CYC(5), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .bus(bus),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .ready(ready), .fault(fault), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int           cyc = 0;
    int           cd = 0;
    int           rd_delay = 30;
    int           err_mode = 0;
    logic [111:0] model_pack = PACK_A;
    int           n_rd = 0, n_init = 0, n_er = 0, n_sv = 0;
    int           rd_t[$], init_t[$], er_t[$], sv_t[$];
    logic [7:0]   init_a[$], init_d[$];
    int           ready_t = -1;
    logic         ready_q = 1'b0;

    function automatic void chk_int(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endfunction

    function automatic void chk_wide(string nm, logic [111:0] act, logic [111:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endfunction

    task automatic chk_reset_outputs(string tag);
        chk_int({tag, "_init_start"}, int'(bus.mpu_init_start), 0);
        chk_int({tag, "_read_start"}, int'(bus.mpu_read_start), 0);
        chk_int({tag, "_error_reset"}, int'(bus.mpu_error_reset), 0);
        chk_int({tag, "_sample_valid"}, int'(sample_valid), 0);
        chk_wide({tag, "_sample_data"}, sample_data, 112'h0);
        chk_int({tag, "_ready"}, int'(ready), 0);
        chk_int({tag, "_fault"}, int'(fault), 0);
        chk_int({tag, "_overrun"}, int'(overrun_cnt), 0);
        chk_int({tag, "_reg_addr"}, int'(bus.mpu_register_addr), 'h6B);
        chk_int({tag, "_reg_data"}, int'(bus.mpu_register_data), 'h00);
        chk_int({tag, "_dev_addr"}, int'(bus.mpu_device_addr), 'hD0);
        chk_int({tag, "_rd_addr"}, int'(bus.mpu_read_start_addr), 'h3B);
    endtask

    // Fake mpu engine and pulse recorder; acts 1 time unit after each rising edge.
    initial begin
        bus.mpu_read_done = 1'b0;
        bus.mpu_error     = 1'b0;
        bus.mpu_data_pack = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.mpu_read_done = 1'b0;
            bus.mpu_data_pack = '0;
            if (bus.mpu_error_reset) begin
                bus.mpu_error = 1'b0;
                n_er++;
                er_t.push_back(cyc);
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.mpu_read_done = 1'b1;
                    if (err_mode == 2) begin
                        bus.mpu_error     = 1'b1;
                        bus.mpu_data_pack = BAD;
                        err_mode          = 0;
                    end else begin
                        bus.mpu_data_pack = model_pack;
                    end
                end
            end
            if (bus.mpu_read_start) begin
                n_rd++;
                rd_t.push_back(cyc);
                if (err_mode == 1) begin
                    bus.mpu_error = 1'b1;
                    err_mode      = 0;
                    cd            = 0;
                end else begin
                    cd = rd_delay;
                end
            end
            if (bus.mpu_init_start) begin
                n_init++;
                init_t.push_back(cyc);
                init_a.push_back(bus.mpu_register_addr);
                init_d.push_back(bus.mpu_register_data);
            end
            if (sample_valid) begin
                n_sv++;
                sv_t.push_back(cyc);
            end
            if (ready && !ready_q) ready_t = cyc;
            ready_q = ready;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got time %0t, expected below 400000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        init_vec_t iv[5];
        rd_vec_t   rv[5];
        int        sv0, er0, rd0;

        iv[0] = '{8'h6B, 8'h00, 0};
        iv[1] = '{8'h19, 8'h07, 21};
        iv[2] = '{8'h1A, 8'h03, 21};
        iv[3] = '{8'h1B, 8'h08, 21};
        iv[4] = '{8'h1C, 8'h08, 21};

        rv[0] = '{30, 0, PACK_A, PACK_A, 31, 0};
        rv[1] = '{30, 0, PACK_A, PACK_A, 31, 0};
        rv[2] = '{10, 0, PACK_B, PACK_B, 11, 0};
        rv[3] = '{30, 1, PACK_A, PACK_A, 31, 1};
        rv[4] = '{30, 2, PACK_B, PACK_B, 31, 1};

        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Test 1: init table
        rd_delay = rv[0].delay; err_mode = rv[0].mode; model_pack = rv[0].pack;
        enable = 1'b1;
        for (int k = 0; k < 300 && !ready; k++) begin @(posedge clk); #2; end
        chk_int("init_ready_rise", int'(ready), 1);
        chk_int("init_pulse_count", init_t.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < init_t.size()) begin
                chk_int($sformatf("init%0d_addr", i), int'(init_a[i]), int'(iv[i].addr));
                chk_int($sformatf("init%0d_data", i), int'(init_d[i]), int'(iv[i].data));
                if (i > 0) chk_int($sformatf("init%0d_gap", i), init_t[i] - init_t[i-1], iv[i].gap);
            end
        end
        if (init_t.size() == 5) chk_int("init_ready_lat", ready_t - init_t[4], 20);

        // Tests 2 and 3: one read per row
        for (int r = 0; r < 5; r++) begin
            rd_delay = rv[r].delay; err_mode = rv[r].mode; model_pack = rv[r].pack;
            sv0 = n_sv; er0 = n_er;
            for (int k = 0; k < 400 && n_sv == sv0; k++) begin @(posedge clk); #2; end
            chk_int($sformatf("row%0d_sv_count", r), n_sv - sv0, 1);
            chk_wide($sformatf("row%0d_data", r), sample_data, rv[r].exp_data);
            chk_int($sformatf("row%0d_err_resets", r), n_er - er0, rv[r].exp_er);
            if (sv_t.size() > 0 && rd_t.size() > 0)
                chk_int($sformatf("row%0d_latency", r), sv_t[sv_t.size()-1] - rd_t[rd_t.size()-1], rv[r].exp_lat);
        end
        if (rd_t.size() >= 7 && er_t.size() >= 2) begin
            chk_int("first_read_lat", rd_t[0] - ready_t, 101);
            chk_int("read_period", rd_t[1] - rd_t[0], 100);
            chk_int("err_reset_lat", er_t[0] - rd_t[3], 1);
            chk_int("retry_gap", rd_t[4] - er_t[0], 6);
            chk_int("retry_gap_dual", rd_t[6] - er_t[1], 6);
        end else begin
            chk_int("read_record_count", rd_t.size(), 7);
        end
        chk_int("sampling_fault", int'(fault), 0);
        chk_int("sampling_overrun", int'(overrun_cnt), 0);

        // enable=0 mid-read: the read still completes and updates sample_data
        model_pack = PACK_D;
        rd0 = n_rd;
        for (int k = 0; k < 200 && n_rd == rd0; k++) begin @(posedge clk); #2; end
        enable = 1'b0;
        sv0 = n_sv;
        repeat (40) begin @(posedge clk); #2; end
        chk_int("disable_sv_count", n_sv - sv0, 1);
        chk_wide("disable_data", sample_data, PACK_D);
        chk_int("disable_ready", int'(ready), 0);
        rd0 = n_rd;
        repeat (150) begin @(posedge clk); #2; end
        chk_int("disable_no_reads", n_rd - rd0, 0);

        // Tests 4 and 5: answers too late -> four timeouts, two dropped ticks, fault
        rd_delay = 150;
        rd_t.delete(); er_t.delete();
        rd0 = n_rd; er0 = n_er; sv0 = n_sv;
        enable = 1'b1;
        for (int k = 0; k < 1500 && !fault; k++) begin @(posedge clk); #2; end
        chk_int("fault_set", int'(fault), 1);
        chk_int("fault_ready", int'(ready), 0);
        chk_int("fault_reads", n_rd - rd0, 4);
        chk_int("fault_err_resets", n_er - er0, 4);
        chk_int("fault_no_samples", n_sv - sv0, 0);
        chk_int("fault_overrun", int'(overrun_cnt), 2);
        if (rd_t.size() >= 2) chk_int("timeout_retry_gap", rd_t[1] - rd_t[0], 56);
        enable = 1'b0;
        repeat (150) begin @(posedge clk); #2; end
        chk_int("fault_cleared", int'(fault), 0);
        chk_int("fault_overrun_held", int'(overrun_cnt), 2);

        // Test 6: asynchronous reset in the middle of a read
        rd_delay = 30;
        enable = 1'b1;
        rd0 = n_rd;
        for (int k = 0; k < 400 && n_rd == rd0; k++) begin @(posedge clk); #2; end
        chk_int("rst6_read_seen", n_rd - rd0, 1);
        repeat (5) begin @(posedge clk); #2; end
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk);
        #2;
        init_t.delete(); init_a.delete(); init_d.delete();
        rst = 1'b0;
        for (int k = 0; k < 50 && init_t.size() == 0; k++) begin @(posedge clk); #2; end
        chk_int("reinit_seen", init_t.size(), 1);
        if (init_t.size() > 0) begin
            chk_int("reinit_addr", int'(init_a[0]), 'h6B);
            chk_int("reinit_data", int'(init_d[0]), 'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
